cache_fill_ctrl: RTL and testbench
==================================

CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 SHALL have parameter WORDS, default 8: words per cache block; the block is 16 bytes.
REQ-002 SHALL have parameter ADDR_W, default 16: byte-address width.
REQ-003 SHALL have a single clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-006 SHALL have port miss_detected, input, 1: cache lookup missed this cycle.
REQ-007 SHALL have port miss_addr, input, 16: byte address of the missing access.
REQ-008 SHALL have port stall, output, 1: pipeline hold while a fill is in progress.
REQ-009 SHALL have port mem_en, output, 1: memory read request strobe.
REQ-010 SHALL have port mem_addr, output, 16: memory read byte address.
REQ-011 SHALL have port mem_data_valid, input, 1: memory returns one word this cycle.
REQ-012 SHALL have port mem_data, input, 16: returned word.
REQ-013 SHALL have port fill_addr, output, 16: byte address of the word being written into the cache.
REQ-014 SHALL have port fill_data, output, 16: word to write into the data array.
REQ-015 SHALL have port fill_data_we, output, 1: data-array write enable.
REQ-016 SHALL have port fill_meta_we, output, 1: metadata write enable.
REQ-017 SHALL have port fill_done, output, 1: one-cycle pulse when a fill completes.

Function
REQ-018 SHALL decode addresses as: offset [3:0], set index [9:4] (64 sets), tag [15:10].
REQ-019 SHALL implement FSM states IDLE, FILL and META.
REQ-020 SHALL transition IDLE->FILL on the edge where miss_detected=1, latching base = {miss_addr[15:4], 4'h0}.
REQ-021 SHALL, in FILL, assert mem_en with mem_addr = base + 2*issue_cnt while issue_cnt < WORDS; one request per cycle, so WORDS consecutive cycles starting the cycle after the miss.
REQ-022 SHALL, in FILL with mem_data_valid=1, assert fill_data_we with fill_data = mem_data and fill_addr = base + 2*rcv_cnt, then increment rcv_cnt.
REQ-023 SHALL accept mem_data_valid on any FILL cycle, including the same cycle as a still-issuing request; returns are in order and latency is arbitrary.
REQ-024 SHALL transition FILL->META on the edge where the WORDS-th valid is accepted.
REQ-025 SHALL, in META (exactly one cycle), assert fill_meta_we and fill_done with fill_addr = base, then return to IDLE.
REQ-026 SHALL assert stall combinationally in FILL and META and deassert it in IDLE.
REQ-027 SHALL ignore miss_detected in FILL and META.
REQ-028 SHALL ignore mem_data_valid in IDLE and META: no write, no counter change.
REQ-029 SHALL size issue_cnt and rcv_cnt at 4 bits with saturation at WORDS; neither counter wraps.
REQ-030 SHALL drive mem_en, fill_data_we, fill_meta_we and fill_done to 0 and mem_addr and fill_addr to base in any state where they are not active.

Reset
REQ-031 SHALL, with rst=1 at a rising edge, set state=IDLE, issue_cnt=0, rcv_cnt=0 and base=0, regardless of current state.
REQ-032 SHALL, after reset, drive stall, mem_en, fill_data_we, fill_meta_we and fill_done to 0 and mem_addr, fill_addr and fill_data to 0.
REQ-033 SHALL abort a fill interrupted by reset mid-FILL with no META cycle; later returns are ignored per REQ-028.

Configuration
REQ-034 SHALL, with macro CACHE_FILL_PERF_EN defined, add output miss_count (16 bits), which increments on each IDLE->FILL transition, wraps 0xFFFF->0 and resets to 0.
REQ-035 SHALL, without CACHE_FILL_PERF_EN, have neither the port nor the counter; all other behaviour is identical.

Structure
REQ-036 SHALL place in shared package cache_pkg: the state typedef, OFFSET_W=4, INDEX_W=6, TAG_W=6 and WORDS_PER_BLOCK=8.
REQ-037 SHALL implement one sub-module, fill_counter: a saturating 4-bit counter with clear, increment and a done flag, instantiated twice (issue and receive).

Verification
REQ-038 SHALL verify: rst, then miss_addr=0x1236 with 2-cycle memory latency -> mem_addr 0x1230..0x123E on cycles 1..8; 8 fill_data_we pulses; META on cycle 11; fill_done once; stall high for cycles 1..11.
REQ-039 SHALL verify: memory returns with gaps (valid every 3rd cycle) -> fill_addr increments by 2 only on valid cycles; META follows the 8th valid.
REQ-040 SHALL verify: miss_detected held high throughout a fill -> no restart; base unchanged; exactly one fill_done.
REQ-041 SHALL verify: rst asserted after 4 returns -> IDLE next cycle; stall=0; later valids produce no writes.
REQ-042 SHALL verify: miss_addr=0xFFFE -> mem_addr 0xFFF0..0xFFFE with no wrap past 0xFFFE.
REQ-043 SHALL verify: with CACHE_FILL_PERF_EN, 3 back-to-back misses -> miss_count=3; after rst, miss_count=0.

Source files
------------

// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cache_pkg
//  Brief    : Shared definitions for the cache fill controller: address
//             field widths, block geometry and the fill FSM state type.
//  Revision : 1.0 - initial release
// ============================================================================
package cache_pkg;

    // Byte-address field split: offset [3:0], set index [9:4], tag [15:10]
    localparam int OFFSET_W        = 4;
    localparam int INDEX_W         = 6;
    localparam int TAG_W           = 6;

    // Default number of 16-bit words in one 16-byte block
    localparam int WORDS_PER_BLOCK = 8;

    // Width of the issue/receive word counters
    localparam int CNT_W           = 4;

    // Width of one memory word
    localparam int DATA_W          = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        META = 2'd2
    } fillState_t;

endpackage
`default_nettype wire

// File: rtl/fill_counter.sv
`default_nettype none
// ============================================================================
//  Module   : fill_counter
//  Brief    : 4-bit up-counter with synchronous clear that saturates at MAX
//             and flags when MAX has been reached.
//  Revision : 1.0 - initial release
// ============================================================================
module fill_counter
    import cache_pkg::*;
#(
    parameter int MAX = WORDS_PER_BLOCK
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count,
    output logic             o_done
);

    localparam logic [CNT_W-1:0] c_MAX = CNT_W'(MAX);

    logic [CNT_W-1:0] r_count;
    logic             w_done;

    assign w_done = (r_count == c_MAX);

    // Clear wins over increment; once at MAX further increments are dropped
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !w_done) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_done  = w_done;

endmodule
`default_nettype wire

// File: rtl/cache_fill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cache_fill_ctrl
//  Brief    : Block fill controller. On a miss it latches the block base,
//             issues one memory read per cycle for every word of the block,
//             writes returned words into the data array in order, then spends
//             one cycle writing metadata and pulsing fill_done.
//             Optional macro CACHE_FILL_PERF_EN adds the 16-bit miss_count
//             output counting started fills.
//  Revision : 1.0 - initial release
// ============================================================================
module cache_fill_ctrl
    import cache_pkg::*;
#(
    parameter int WORDS  = WORDS_PER_BLOCK,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_addr,
    output logic              stall,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_data_valid,
    input  logic [DATA_W-1:0] mem_data,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              fill_data_we,
    output logic              fill_meta_we,
`ifdef CACHE_FILL_PERF_EN
    output logic [15:0]       miss_count,
`endif
    output logic              fill_done
);

    localparam logic [ADDR_W-1:0] c_OFFSET_MASK = ADDR_W'((1 << OFFSET_W) - 1);
    localparam logic [CNT_W-1:0]  c_LAST_WORD   = CNT_W'(WORDS - 1);

    fillState_t        r_state;
    logic [ADDR_W-1:0] r_base;

    logic              w_start;
    logic              w_cntClr;
    logic              w_issueInc;
    logic              w_issueDone;
    logic [CNT_W-1:0]  w_issueCnt;
    logic              w_accept;
    logic              w_rcvDone;
    logic [CNT_W-1:0]  w_rcvCnt;
    logic              w_lastAccept;
    logic [ADDR_W-1:0] w_issueOff;
    logic [ADDR_W-1:0] w_rcvOff;

    // A miss is only taken from IDLE; misses during a fill are ignored
    assign w_start      = (r_state == IDLE) && miss_detected;
    assign w_cntClr     = rst || w_start;

    // Requests go out one per cycle until every word has been asked for
    assign w_issueInc   = (r_state == FILL) && !w_issueDone;

    // Returns are accepted only while filling, may overlap with issuing
    assign w_accept     = (r_state == FILL) && mem_data_valid && !w_rcvDone;
    assign w_lastAccept = w_accept && (w_rcvCnt == c_LAST_WORD);

    // Word index to byte offset (16-bit words)
    assign w_issueOff   = ADDR_W'({w_issueCnt, 1'b0});
    assign w_rcvOff     = ADDR_W'({w_rcvCnt, 1'b0});

    fill_counter #(
        .MAX (WORDS)
    ) u_issueCnt (
        .clk     (clk),
        .i_clr   (w_cntClr),
        .i_inc   (w_issueInc),
        .o_count (w_issueCnt),
        .o_done  (w_issueDone)
    );

    fill_counter #(
        .MAX (WORDS)
    ) u_rcvCnt (
        .clk     (clk),
        .i_clr   (w_cntClr),
        .i_inc   (w_accept),
        .o_count (w_rcvCnt),
        .o_done  (w_rcvDone)
    );

    // Fill sequencing: IDLE -> FILL on miss, FILL -> META on last word, META -> IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_base  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (miss_detected) begin
                        r_state <= FILL;
                        r_base  <= miss_addr & ~c_OFFSET_MASK;
                    end
                end
                FILL: begin
                    if (w_lastAccept) begin
                        r_state <= META;
                    end
                end
                META: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign stall        = (r_state == FILL) || (r_state == META);
    assign mem_en       = w_issueInc;
    assign mem_addr     = w_issueInc ? (r_base + w_issueOff) : r_base;
    assign fill_data_we = w_accept;
    assign fill_data    = w_accept ? mem_data : '0;
    assign fill_addr    = w_accept ? (r_base + w_rcvOff) : r_base;
    assign fill_meta_we = (r_state == META);
    assign fill_done    = (r_state == META);

`ifdef CACHE_FILL_PERF_EN
    logic [15:0] r_missCount;

    // Counts started fills; wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_missCount <= '0;
        end else if (w_start) begin
            r_missCount <= r_missCount + 16'd1;
        end
    end

    assign miss_count = r_missCount;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_fill_ctrl
//  Brief    : Self-checking bench for cache_fill_ctrl with a transaction-level
//             reference model and an in-order memory responder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cache_fill_ctrl;

    localparam int WORDS = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_addr = '0;
    logic        stall;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic        mem_data_valid = 1'b0;
    logic [15:0] mem_data = '0;
    logic [15:0] fill_addr;
    logic [15:0] fill_data;
    logic        fill_data_we;
    logic        fill_meta_we;
    logic        fill_done;
`ifdef CACHE_FILL_PERF_EN
    logic [15:0] miss_count;
`endif

    cache_fill_ctrl #(
        .WORDS  (WORDS),
        .ADDR_W (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .miss_detected  (miss_detected),
        .miss_addr      (miss_addr),
        .stall          (stall),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .mem_data_valid (mem_data_valid),
        .mem_data       (mem_data),
        .fill_addr      (fill_addr),
        .fill_data      (fill_data),
        .fill_data_we   (fill_data_we),
        .fill_meta_we   (fill_meta_we),
`ifdef CACHE_FILL_PERF_EN
        .miss_count     (miss_count),
`endif
        .fill_done      (fill_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errs    = 0;
    int cycleNo = 0;

    // Reference model: a fill is "in progress" with some words requested
    // and some words returned; the metadata cycle follows the last return.
    bit          mActive;
    bit          mMeta;
    int          mIssued;
    int          mRcv;
    logic [15:0] mBase;
    logic [15:0] mMissCount;

    // Memory responder: cycle at which each outstanding request may return
    int readyQ[$];
    int latency  = 2;
    int gapEvery = 1;

    // Observation statistics for the current scenario
    int          doneCnt, doneCycle, stallCnt, wrCnt, missCycle;
    logic [15:0] lastMemAddr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clearStats();
        doneCnt = 0; doneCycle = -1; stallCnt = 0; wrCnt = 0; lastMemAddr = '0;
    endtask

    // One clock cycle: drive inputs, check all outputs against the model,
    // then advance the model across the coming rising edge.
    task automatic tick(input logic r, input logic m, input logic [15:0] a, input logic forceV);
        logic        v;
        logic [15:0] d;
        logic        eMemEn, eWe;
        logic [15:0] eMemAddr, eFillAddr, eFillData;
        @(posedge clk);
        #1;
        v = forceV;
        if (!v && readyQ.size() > 0 && readyQ[0] <= cycleNo && (cycleNo % gapEvery) == 0) begin
            v = 1'b1;
            void'(readyQ.pop_front());
        end
        d = 16'($urandom);
        rst = r; miss_detected = m; miss_addr = a; mem_data_valid = v; mem_data = d;
        #1;
        eMemEn    = mActive && (mIssued < WORDS);
        eMemAddr  = eMemEn ? mBase + 16'(2 * mIssued) : mBase;
        eWe       = mActive && v;
        eFillAddr = eWe ? mBase + 16'(2 * mRcv) : mBase;
        eFillData = eWe ? d : 16'h0;
        chk("stall",        stall,        mActive || mMeta);
        chk("mem_en",       mem_en,       eMemEn);
        chk("mem_addr",     mem_addr,     eMemAddr);
        chk("fill_data_we", fill_data_we, eWe);
        chk("fill_addr",    fill_addr,    eFillAddr);
        chk("fill_data",    fill_data,    eFillData);
        chk("fill_meta_we", fill_meta_we, mMeta);
        chk("fill_done",    fill_done,    mMeta);
`ifdef CACHE_FILL_PERF_EN
        chk("miss_count",   miss_count,   mMissCount);
`endif
        if (fill_done) begin doneCnt++; doneCycle = cycleNo; end
        if (stall) stallCnt++;
        if (fill_data_we) wrCnt++;
        if (mem_en) lastMemAddr = mem_addr;
        if (r) begin
            mActive = 0; mMeta = 0; mIssued = 0; mRcv = 0; mBase = '0; mMissCount = '0;
            readyQ.delete();
        end else if (mMeta) begin
            mMeta = 0;
        end else if (mActive) begin
            if (eMemEn) begin
                readyQ.push_back(cycleNo + latency);
                mIssued++;
            end
            if (v) begin
                mRcv++;
                if (mRcv == WORDS) begin
                    mActive = 0;
                    mMeta   = 1;
                end
            end
        end else if (m) begin
            mActive = 1; mIssued = 0; mRcv = 0;
            mBase = {a[15:4], 4'h0};
            mMissCount = mMissCount + 16'd1;
        end
        cycleNo++;
    endtask

    // Start a fill and run until fill_done, or until stopW words were written
    task automatic runFill(input logic [15:0] a, input bit hold, input int stopW);
        bit finished;
        clearStats();
        finished  = 0;
        missCycle = cycleNo;
        tick(1'b0, 1'b1, a, 1'b0);
        for (int i = 0; i < 80 && !finished; i++) begin
            tick(1'b0, hold, a, 1'b0);
            if (doneCnt > 0) finished = 1;
            if (stopW > 0 && wrCnt >= stopW) finished = 1;
        end
        vectors++;
        if (!finished) begin
            errs++;
            $error("FAIL fill_timeout: observed no completion expected completion within 80 cycles");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        mActive = 0; mMeta = 0; mIssued = 0; mRcv = 0; mBase = '0; mMissCount = '0;

        // Reset state
        tick(1'b1, 1'b0, 16'h0, 1'b0);
        tick(1'b1, 1'b1, 16'h5555, 1'b1);
        tick(1'b0, 1'b0, 16'h0, 1'b0);

        // Basic fill, 2-cycle memory latency
        latency = 2; gapEvery = 1;
        runFill(16'h1236, 1'b0, 0);
        chk("basic_meta_cycle", doneCycle - missCycle, 11);
        chk("basic_done_cnt",   doneCnt, 1);
        chk("basic_writes",     wrCnt, 8);
        chk("basic_stall_cyc",  stallCnt, 11);
        chk("basic_last_req",   lastMemAddr, 16'h123E);
        tick(1'b0, 1'b0, 16'h0, 1'b0);

        // Returns with gaps: valid every 3rd cycle
        latency = 1; gapEvery = 3;
        runFill(16'($urandom), 1'b0, 0);
        chk("gap_done_cnt", doneCnt, 1);
        chk("gap_writes",   wrCnt, 8);
        tick(1'b0, 1'b0, 16'h0, 1'b0);

        // Miss held high for the whole fill
        latency = int'($urandom_range(1, 4)); gapEvery = 1;
        runFill(16'h4A5C, 1'b1, 0);
        chk("hold_done_cnt", doneCnt, 1);
        chk("hold_writes",   wrCnt, 8);
        tick(1'b0, 1'b0, 16'h0, 1'b0);

        // Reset after 4 returns, then stray valids while idle
        latency = 1; gapEvery = 1;
        runFill(16'h0F27, 1'b0, 4);
        chk("abort_writes_before", wrCnt, 4);
        tick(1'b1, 1'b0, 16'h0, 1'b0);
        clearStats();
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 16'h0, 1'b1);
        chk("abort_stall_cyc", stallCnt, 0);
        chk("abort_writes",    wrCnt, 0);
        chk("abort_done_cnt",  doneCnt, 0);

        // Top of address space: no wrap past 0xFFFE
        latency = 3; gapEvery = 1;
        runFill(16'hFFFE, 1'b0, 0);
        chk("top_last_req", lastMemAddr, 16'hFFFE);
        chk("top_done_cnt", doneCnt, 1);
        tick(1'b0, 1'b0, 16'h0, 1'b0);

        // Randomised fills
        for (int n = 0; n < 6; n++) begin
            latency  = int'($urandom_range(1, 5));
            gapEvery = int'($urandom_range(1, 2));
            runFill(16'($urandom), 1'b0, 0);
            chk("rand_done_cnt", doneCnt, 1);
            chk("rand_writes",   wrCnt, 8);
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick(1'b0, 1'b0, 16'h0, 1'b0);
        end

`ifdef CACHE_FILL_PERF_EN
        // Three back-to-back misses, then reset
        tick(1'b1, 1'b0, 16'h0, 1'b0);
        latency = 1; gapEvery = 1;
        for (int n = 0; n < 3; n++) runFill(16'($urandom), 1'b0, 0);
        tick(1'b0, 1'b0, 16'h0, 1'b0);
        chk("perf_count3", miss_count, 16'd3);
        tick(1'b1, 1'b0, 16'h0, 1'b0);
        tick(1'b0, 1'b0, 16'h0, 1'b0);
        chk("perf_count_rst", miss_count, 16'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
`default_nettype wire
